gather_fwd_pipe: RTL and testbench

GATHER_FWD_PIPE -- requirements
Module: gather_fwd_pipe

---
 rtl/gather_fwd_pipe_if.sv | 30 +++
 rtl/gather_fwd_pipe.sv | 105 ++++++++++
 tb/tb_gather_fwd_pipe.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gather_fwd_pipe_if.sv
// Purpose: update-in / write-back-out bundle for gather_fwd_pipe.
// Latency: none (signal grouping only).
// Backpressure: none; the consumer accepts one update per cycle.
interface gather_fwd_pipe_if #(
    parameter int PAR_SIZE_W  = 18,
    parameter int URAM_DATA_W = 32
);
    logic [31:0]             update_value;
    logic [31:0]             update_dest;
    logic [URAM_DATA_W-1:0]  dest_attr;
    logic                    input_valid;
    logic                    par_clear;
    logic [URAM_DATA_W-1:0]  WData;
    logic [PAR_SIZE_W-1:0]   WAddr;
    logic                    Wvalid;
    logic                    par_active;
    logic [PAR_SIZE_W:0]     act_count;

    // Producer of updates / observer of write-backs.
    modport master (
        output update_value, update_dest, dest_attr, input_valid, par_clear,
        input  WData, WAddr, Wvalid, par_active, act_count
    );

    // The gather pipe itself.
    modport slave (
        input  update_value, update_dest, dest_attr, input_valid, par_clear,
        output WData, WAddr, Wvalid, par_active, act_count
    );
endinterface

// File: rtl/gather_fwd_pipe.sv
// Purpose: reduce incoming updates against the stored attribute, forwarding recent writes to hide stale reads.
// Latency: 1 cycle from input to Wvalid/WAddr/WData; status flags update on the same edge.
// Backpressure: none; one update accepted every cycle, never stalls.
module gather_fwd_pipe #(
    parameter int PAR_SIZE_W  = 18,
    parameter int URAM_DATA_W = 32,
    parameter int FWD_DEPTH   = 4,
    parameter int MODE        = 0
) (
    input  logic               clk,
    input  logic               rst,
    gather_fwd_pipe_if.slave   bus
);

    logic [PAR_SIZE_W-1:0]  dest;
    logic [30:0]            val;
    logic [30:0]            old_val;
    logic [30:0]            new_val;
    logic [31:0]            sum;
    logic                   wr;
    logic [URAM_DATA_W-1:0] wdata_nxt;

    // Recent-write history; entry 0 is the newest.
    logic [PAR_SIZE_W-1:0]  hist_addr [FWD_DEPTH];
    logic [30:0]            hist_dat  [FWD_DEPTH];
    logic [FWD_DEPTH-1:0]   hist_vld;

    assign dest = bus.update_dest[PAR_SIZE_W-1:0];
    assign val  = bus.update_value[30:0];

    // Bits outside the payload/address fields carry no meaning here.
    wire unused_bits = &{1'b0, bus.update_value[31],
                         bus.update_dest[31:PAR_SIZE_W], bus.dest_attr[31]};

    // Forwarding lookup: scan oldest to newest so the newest match wins;
    // a partition clear hides the whole history from this cycle's input.
    always_comb begin
        old_val = bus.dest_attr[30:0];
        for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
            if (!bus.par_clear && hist_vld[i] && (hist_addr[i] == dest)) begin
                old_val = hist_dat[i];
            end
        end
    end

    // Reduction: min-improve or saturating accumulate; bit 31 marks the vertex active.
    always_comb begin
        wr      = 1'b0;
        new_val = val;
        sum     = {1'b0, old_val} + {1'b0, val};
        if (MODE == 0) begin
            wr      = bus.input_valid && (val < old_val);
            new_val = val;
        end else begin
            wr      = bus.input_valid && (val != '0);
            new_val = sum[31] ? 31'h7FFF_FFFF : sum[30:0];
        end
        wdata_nxt       = bus.dest_attr;
        wdata_nxt[31:0] = {1'b1, new_val};
    end

    // Registered write-back port and partition activity status.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.Wvalid     <= 1'b0;
            bus.WAddr      <= '0;
            bus.WData      <= '0;
            bus.par_active <= 1'b0;
            bus.act_count  <= '0;
        end else begin
            bus.Wvalid <= wr;
            if (bus.input_valid) begin
                bus.WAddr <= dest;
                bus.WData <= wdata_nxt;
            end
            if (bus.par_clear) begin
                bus.par_active <= wr;
                bus.act_count  <= {{PAR_SIZE_W{1'b0}}, wr};
            end else if (wr) begin
                bus.par_active <= 1'b1;
                if (bus.act_count != '1) begin
                    bus.act_count <= bus.act_count + 1'b1;
                end
            end
        end
    end

    // History shifts only on an issued write; a clear keeps at most the coincident write.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_vld <= '0;
        end else if (wr) begin
            for (int i = FWD_DEPTH - 1; i > 0; i--) begin
                hist_addr[i] <= hist_addr[i-1];
                hist_dat[i]  <= hist_dat[i-1];
            end
            hist_addr[0] <= dest;
            hist_dat[0]  <= new_val;
            hist_vld     <= bus.par_clear ? FWD_DEPTH'(1) : FWD_DEPTH'({hist_vld, 1'b1});
        end else if (bus.par_clear) begin
            hist_vld <= '0;
        end
    end

endmodule

// File: tb/tb_gather_fwd_pipe.sv
module tb_gather_fwd_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // dut0: min-reduce, wide words; dut1: accumulate; dut2: min-reduce, shallow history, narrow address.
    gather_fwd_pipe_if #(.PAR_SIZE_W(18), .URAM_DATA_W(40)) b0 ();
    gather_fwd_pipe_if #(.PAR_SIZE_W(18), .URAM_DATA_W(32)) b1 ();
    gather_fwd_pipe_if #(.PAR_SIZE_W(4),  .URAM_DATA_W(32)) b2 ();

    gather_fwd_pipe #(.PAR_SIZE_W(18), .URAM_DATA_W(40), .FWD_DEPTH(4), .MODE(0))
        dut0 (.clk(clk), .rst(rst), .bus(b0));
    gather_fwd_pipe #(.PAR_SIZE_W(18), .URAM_DATA_W(32), .FWD_DEPTH(4), .MODE(1))
        dut1 (.clk(clk), .rst(rst), .bus(b1));
    gather_fwd_pipe #(.PAR_SIZE_W(4), .URAM_DATA_W(32), .FWD_DEPTH(2), .MODE(0))
        dut2 (.clk(clk), .rst(rst), .bus(b2));

    typedef struct {
        int          sel;
        logic        vld;
        logic [17:0] addr;
        logic [39:0] dat;
        string       name;
    } exp_t;

    exp_t sb[$];

    localparam logic [39:0] A5_100 = {8'hA5, 32'd100};

    task automatic set_in(input int sel, input logic v, input logic [31:0] val,
                          input logic [31:0] dest, input logic [39:0] attr, input logic clr);
        b0.input_valid = 0; b0.par_clear = 0; b0.update_value = 0; b0.update_dest = 0; b0.dest_attr = 0;
        b1.input_valid = 0; b1.par_clear = 0; b1.update_value = 0; b1.update_dest = 0; b1.dest_attr = 0;
        b2.input_valid = 0; b2.par_clear = 0; b2.update_value = 0; b2.update_dest = 0; b2.dest_attr = 0;
        case (sel)
            0: begin b0.input_valid = v; b0.par_clear = clr; b0.update_value = val;
                     b0.update_dest = dest; b0.dest_attr = attr; end
            1: begin b1.input_valid = v; b1.par_clear = clr; b1.update_value = val;
                     b1.update_dest = dest; b1.dest_attr = attr[31:0]; end
            2: begin b2.input_valid = v; b2.par_clear = clr; b2.update_value = val;
                     b2.update_dest = dest; b2.dest_attr = attr[31:0]; end
            default: ;
        endcase
    endtask

    task automatic get_out(input int sel, output logic vld, output logic [17:0] addr,
                           output logic [39:0] dat, output logic act, output logic [18:0] cnt);
        case (sel)
            0: begin vld = b0.Wvalid; addr = b0.WAddr; dat = b0.WData;
                     act = b0.par_active; cnt = b0.act_count; end
            1: begin vld = b1.Wvalid; addr = b1.WAddr; dat = 40'(b1.WData);
                     act = b1.par_active; cnt = b1.act_count; end
            default: begin vld = b2.Wvalid; addr = 18'(b2.WAddr); dat = 40'(b2.WData);
                     act = b2.par_active; cnt = 19'(b2.act_count); end
        endcase
    endtask

    // Drive one input cycle, push its expected write, then pop and compare after the edge.
    task automatic cycle(input int sel, input logic v, input logic [31:0] val,
                         input logic [31:0] dest, input logic [39:0] attr, input logic clr,
                         input logic ev, input logic [17:0] ea, input logic [39:0] ed,
                         input string name);
        exp_t        e;
        logic        g_vld, g_act;
        logic [17:0] g_addr;
        logic [39:0] g_dat;
        logic [18:0] g_cnt;
        set_in(sel, v, val, dest, attr, clr);
        sb.push_back('{sel: sel, vld: ev, addr: ea, dat: ed, name: name});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        get_out(e.sel, g_vld, g_addr, g_dat, g_act, g_cnt);
        total++;
        if (g_vld !== e.vld) begin
            bad++;
            $display("FAIL %s Wvalid: got %0b want %0b", e.name, g_vld, e.vld);
        end
        if (e.vld) begin
            total++;
            if (g_addr !== e.addr) begin
                bad++;
                $display("FAIL %s WAddr: got %0h want %0h", e.name, g_addr, e.addr);
            end
            total++;
            if (g_dat !== e.dat) begin
                bad++;
                $display("FAIL %s WData: got %0h want %0h", e.name, g_dat, e.dat);
            end
        end
        set_in(-1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset;
        logic        vld, act;
        logic [17:0] addr;
        logic [39:0] dat;
        logic [18:0] cnt;
        rst = 1'b1;
        set_in(0, 1, 40, 5, A5_100, 0);
        @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            get_out(s, vld, addr, dat, act, cnt);
            total++;
            if ({vld, addr, dat, act, cnt} !== '0) begin
                bad++;
                $display("FAIL reset_outs dut%0d: got vld=%0b addr=%0h dat=%0h act=%0b cnt=%0d want all 0",
                         s, vld, addr, dat, act, cnt);
            end
        end
        set_in(-1, 0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic test_fwd_suppress;
        logic        vld, act;
        logic [17:0] addr;
        logic [39:0] dat;
        logic [18:0] cnt;
        cycle(0, 1, 40, 5, A5_100, 0, 1, 5, {8'hA5, 1'b1, 31'd40}, "fwd_first");
        cycle(0, 1, 60, 5, A5_100, 0, 0, 0, 0, "fwd_suppressed");
        get_out(0, vld, addr, dat, act, cnt);
        total++;
        if (act !== 1'b1 || cnt !== 19'd1) begin
            bad++;
            $display("FAIL fwd_status: got act=%0b cnt=%0d want act=1 cnt=1", act, cnt);
        end
    endtask

    task automatic test_back_to_back;
        logic        vld, act;
        logic [17:0] addr;
        logic [39:0] dat;
        logic [18:0] cnt;
        cycle(0, 0, 0, 0, 0, 1, 0, 0, 0, "b2b_clear");
        get_out(0, vld, addr, dat, act, cnt);
        total++;
        if (act !== 1'b0 || cnt !== 19'd0) begin
            bad++;
            $display("FAIL b2b_clear_status: got act=%0b cnt=%0d want act=0 cnt=0", act, cnt);
        end
        cycle(0, 1, 40, 5, A5_100, 0, 1, 5, {8'hA5, 1'b1, 31'd40}, "b2b_w40");
        cycle(0, 1, 30, 5, A5_100, 0, 1, 5, {8'hA5, 1'b1, 31'd30}, "b2b_w30");
        get_out(0, vld, addr, dat, act, cnt);
        total++;
        if (act !== 1'b1 || cnt !== 19'd2) begin
            bad++;
            $display("FAIL b2b_status: got act=%0b cnt=%0d want act=1 cnt=2", act, cnt);
        end
        cycle(0, 1, 35, 5, A5_100, 0, 0, 0, 0, "b2b_fwd_newest");
        cycle(0, 1, 30, 5, A5_100, 0, 0, 0, 0, "b2b_equal_no_write");
        cycle(0, 1, 99, 6, A5_100, 0, 1, 6, {8'hA5, 1'b1, 31'd99}, "b2b_other_dest");
    endtask

    task automatic test_clear_with_write;
        logic        vld, act;
        logic [17:0] addr;
        logic [39:0] dat;
        logic [18:0] cnt;
        cycle(0, 1, 50, 5, A5_100, 1, 1, 5, {8'hA5, 1'b1, 31'd50}, "clr_write");
        get_out(0, vld, addr, dat, act, cnt);
        total++;
        if (act !== 1'b1 || cnt !== 19'd1) begin
            bad++;
            $display("FAIL clr_status: got act=%0b cnt=%0d want act=1 cnt=1", act, cnt);
        end
        cycle(0, 1, 45, 5, A5_100, 0, 1, 5, {8'hA5, 1'b1, 31'd45}, "clr_hist_only_new");
        cycle(0, 1, 99, 6, A5_100, 0, 1, 6, {8'hA5, 1'b1, 31'd99}, "clr_old_flushed");
    endtask

    task automatic test_accumulate;
        logic        vld, act;
        logic [17:0] addr;
        logic [39:0] dat;
        logic [18:0] cnt;
        cycle(1, 1, 5, 7, 10, 0, 1, 7, {8'h0, 1'b1, 31'd15}, "acc_15");
        cycle(1, 1, 5, 7, 10, 0, 1, 7, {8'h0, 1'b1, 31'd20}, "acc_20");
        cycle(1, 1, 5, 32'hFFFC_0007, 10, 0, 1, 7, {8'h0, 1'b1, 31'd25}, "acc_25_hi_dest");
        cycle(1, 1, 32'h7FFF_FFF0, 7, 10, 0, 1, 7, {8'h0, 1'b1, 31'h7FFF_FFFF}, "acc_saturate");
        cycle(1, 1, 0, 7, 10, 0, 0, 0, 0, "acc_zero_no_write");
        cycle(1, 1, 1, 7, 10, 0, 1, 7, {8'h0, 1'b1, 31'h7FFF_FFFF}, "acc_stay_saturated");
        get_out(1, vld, addr, dat, act, cnt);
        total++;
        if (act !== 1'b1 || cnt !== 19'd5) begin
            bad++;
            $display("FAIL acc_status: got act=%0b cnt=%0d want act=1 cnt=5", act, cnt);
        end
    endtask

    task automatic test_depth_miss;
        cycle(2, 1, 10, 1, 50, 0, 1, 1, {8'h0, 1'b1, 31'd10}, "depth_w1");
        cycle(2, 1, 10, 2, 50, 0, 1, 2, {8'h0, 1'b1, 31'd10}, "depth_w2");
        cycle(2, 1, 10, 3, 50, 0, 1, 3, {8'h0, 1'b1, 31'd10}, "depth_w3");
        cycle(2, 1, 20, 1, 50, 0, 1, 1, {8'h0, 1'b1, 31'd20}, "depth_evicted_miss");
        cycle(2, 1, 20, 3, 50, 0, 0, 0, 0, "depth_still_hit");
    endtask

    task automatic test_count_saturate;
        logic        vld, act;
        logic [17:0] addr;
        logic [39:0] dat;
        logic [18:0] cnt;
        for (int i = 0; i < 40; i++) begin
            cycle(2, 1, 1000 - i, 4, 2000, 0, 1, 4, {8'h0, 1'b1, 31'(1000 - i)}, "sat_stream");
        end
        get_out(2, vld, addr, dat, act, cnt);
        total++;
        if (act !== 1'b1 || cnt !== 19'd31) begin
            bad++;
            $display("FAIL sat_count: got act=%0b cnt=%0d want act=1 cnt=31", act, cnt);
        end
        cycle(2, 0, 0, 0, 0, 1, 0, 0, 0, "sat_clear");
        get_out(2, vld, addr, dat, act, cnt);
        total++;
        if (act !== 1'b0 || cnt !== 19'd0) begin
            bad++;
            $display("FAIL sat_clear_status: got act=%0b cnt=%0d want act=0 cnt=0", act, cnt);
        end
    endtask

    task automatic test_reset_midstream;
        logic        vld, act;
        logic [17:0] addr;
        logic [39:0] dat;
        logic [18:0] cnt;
        cycle(1, 1, 5, 9, 10, 0, 1, 9, {8'h0, 1'b1, 31'd15}, "rst_pre");
        rst = 1'b1;
        set_in(1, 1, 5, 9, 10, 0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            get_out(1, vld, addr, dat, act, cnt);
            total++;
            if ({vld, addr, dat, act, cnt} !== '0) begin
                bad++;
                $display("FAIL rst_mid cycle%0d: got vld=%0b addr=%0h dat=%0h act=%0b cnt=%0d want all 0",
                         k, vld, addr, dat, act, cnt);
            end
        end
        set_in(-1, 0, 0, 0, 0, 0);
        rst = 1'b0;
        cycle(1, 1, 5, 9, 10, 0, 1, 9, {8'h0, 1'b1, 31'd15}, "rst_post_empty_hist");
        get_out(1, vld, addr, dat, act, cnt);
        total++;
        if (act !== 1'b1 || cnt !== 19'd1) begin
            bad++;
            $display("FAIL rst_post_status: got act=%0b cnt=%0d want act=1 cnt=1", act, cnt);
        end
    endtask

    initial begin
        set_in(-1, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        test_fwd_suppress;
        test_back_to_back;
        test_clear_with_write;
        test_accumulate;
        test_depth_miss;
        test_count_saturate;
        test_reset_midstream;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
